// File: rtl/idct8_mac.sv
// 8-point forward/inverse DCT on a single shared multiplier.
// Loads a block of 8 samples, then computes and presents the 8 results in turn.
module idct8_mac #(
  parameter int IN_W   = 12,
  parameter int OUT_W  = 9,
  parameter int COEF_W = 10,
  parameter int SHIFT  = 9
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              i_mode,
  input  logic              i_valid,
  input  logic [IN_W-1:0]   i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_data,
  output logic [2:0]        o_index,
  output logic              o_last,
  input  logic              i_ready
);

  localparam int ACC_W  = IN_W + COEF_W + 3;
  localparam int PROD_W = IN_W + COEF_W;
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [2:0]                r_load_cnt;
  logic [3:0]                r_k;
  logic [2:0]                r_n;
  logic                      r_mode;
  logic signed [IN_W-1:0]    r_buf [8];
  logic signed [PROD_W-1:0]  r_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ready;
  logic                      r_valid;
  logic [OUT_W-1:0]          r_data;
  logic [2:0]                r_index;
  logic                      r_last;

  logic                      w_accept;
  logic                      w_handshake;
  logic [2:0]                w_row;
  logic [2:0]                w_col;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [IN_W-1:0]    w_samp;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_rnd;
  logic signed [ACC_W-1:0]   w_shift;
  logic [OUT_W-1:0]          w_sat;

  // Q8 cosine: angle (2r+1)c*pi/16 folded into the first quadrant (index 0..8).
  function automatic logic signed [COEF_W-1:0] cos_coef(input logic [2:0] r, input logic [2:0] c);
    logic [4:0] m;
    logic [4:0] f1;
    logic [4:0] f2;
    logic       neg;
    logic [8:0] mag;
    logic signed [COEF_W-1:0] val;
    m   = {1'b0, r, 1'b1} * {2'b00, c};
    f1  = (m > 5'd16) ? (5'd0 - m) : m;
    neg = (f1 > 5'd8);
    f2  = neg ? (5'd16 - f1) : f1;
    case (f2)
      5'd0:    mag = 9'd256;
      5'd1:    mag = 9'd251;
      5'd2:    mag = 9'd237;
      5'd3:    mag = 9'd213;
      5'd4:    mag = 9'd181;
      5'd5:    mag = 9'd142;
      5'd6:    mag = 9'd98;
      5'd7:    mag = 9'd50;
      default: mag = 9'd0;
    endcase
    if (c == 3'd0) mag = 9'd181;
    val = COEF_W'({1'b0, mag});
    if (neg) val = -val;
    return val;
  endfunction

  assign w_accept    = (r_state == S_LOAD) && r_ready && i_valid;
  assign w_handshake = (r_state == S_OUT) && r_valid && i_ready;
  assign w_row       = r_mode ? r_k[2:0] : r_n;
  assign w_col       = r_mode ? r_n : r_k[2:0];
  assign w_coef      = cos_coef(w_row, w_col);
  assign w_samp      = r_buf[r_k[2:0]];
  assign w_prod      = PROD_W'(w_coef) * PROD_W'(w_samp);
  // Product is registered, so the sum completes one cycle after the last product.
  assign w_sum       = r_acc + ACC_W'(r_prod);
  assign w_rnd       = w_sum + RND;
  assign w_shift     = w_rnd >>> SHIFT;

  // Clamp the rounded sum to the output range.
  always_comb begin
    if (w_shift > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (w_shift < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      w_sat = w_shift[OUT_W-1:0];
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_accept && (r_load_cnt == 3'd7)) w_next = S_MAC;
        else                                  w_next = S_LOAD;
      end
      S_MAC: begin
        if (r_k == 4'd8) w_next = S_OUT;
        else             w_next = S_MAC;
      end
      S_OUT: begin
        if (w_handshake) w_next = (r_n == 3'd7) ? S_LOAD : S_MAC;
        else             w_next = S_OUT;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // State register, sample buffer, MAC datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state    <= S_LOAD;
      r_load_cnt <= 3'd0;
      r_k        <= 4'd0;
      r_n        <= 3'd0;
      r_mode     <= 1'b0;
      r_prod     <= {PROD_W{1'b0}};
      r_acc      <= {ACC_W{1'b0}};
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= {OUT_W{1'b0}};
      r_index    <= 3'd0;
      r_last     <= 1'b0;
      for (int i = 0; i < 8; i++) r_buf[i] <= {IN_W{1'b0}};
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_LOAD);
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_buf[r_load_cnt] <= $signed(i_data);
            r_load_cnt        <= r_load_cnt + 3'd1;
            if (r_load_cnt == 3'd0) r_mode <= i_mode;
            if (r_load_cnt == 3'd7) begin
              r_n    <= 3'd0;
              r_k    <= 4'd0;
              r_acc  <= {ACC_W{1'b0}};
              r_prod <= {PROD_W{1'b0}};
            end
          end
        end
        S_MAC: begin
          r_k    <= r_k + 4'd1;
          r_acc  <= w_sum;
          r_prod <= w_prod;
          if (r_k == 4'd8) begin
            r_valid <= 1'b1;
            r_data  <= w_sat;
            r_index <= r_n;
            r_last  <= (r_n == 3'd7);
          end
        end
        S_OUT: begin
          if (w_handshake) begin
            r_valid <= 1'b0;
            if (r_n != 3'd7) begin
              r_n    <= r_n + 3'd1;
              r_k    <= 4'd0;
              r_acc  <= {ACC_W{1'b0}};
              r_prod <= {PROD_W{1'b0}};
            end
          end
        end
        default: r_k <= 4'd0;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_index = r_index;
  assign o_last  = r_last;

endmodule

// File: tb/tb_idct8_mac.sv
// Scoreboard bench for idct8_mac: directed vectors plus random blocks against a cosine model.
module tb_idct8_mac;
  localparam int IN_W  = 12;
  localparam int OUT_W = 9;
  localparam int SHIFT = 9;

  logic             i_clk   = 1'b0;
  logic             i_arstn = 1'b0;
  logic             i_mode  = 1'b0;
  logic             i_valid = 1'b0;
  logic [IN_W-1:0]  i_data  = '0;
  logic             i_ready = 1'b1;
  logic             o_ready;
  logic             o_valid;
  logic [OUT_W-1:0] o_data;
  logic [2:0]       o_index;
  logic             o_last;

  idct8_mac dut (
    .i_clk  (i_clk),
    .i_arstn(i_arstn),
    .i_mode (i_mode),
    .i_valid(i_valid),
    .i_data (i_data),
    .o_ready(o_ready),
    .o_valid(o_valid),
    .o_data (o_data),
    .o_index(o_index),
    .o_last (o_last),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int data;
    int idx;
    bit last;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rdy_random = 1'b0;
  int   stall_left = 0;
  int   stall_idx  = 0;

  function automatic void check_eq(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic int coef(int r, int c);
    real v;
    v = 256.0 * $cos(real'((2 * r + 1) * c) * 3.14159265358979 / 16.0);
    if (c == 0) v = v / $sqrt(2.0);
    return int'($floor(v + 0.5));
  endfunction

  function automatic int scale(int acc);
    int q;
    int r;
    q = acc + 2 ** (SHIFT - 1);
    r = (q >= 0) ? q / (2 ** SHIFT) : -((-q + 2 ** SHIFT - 1) / (2 ** SHIFT));
    if (r > 2 ** (OUT_W - 1) - 1) r = 2 ** (OUT_W - 1) - 1;
    if (r < -(2 ** (OUT_W - 1))) r = -(2 ** (OUT_W - 1));
    return r;
  endfunction

  task automatic model_block(input bit mode, input int s[8], output int r[8]);
    for (int n = 0; n < 8; n++) begin
      int acc;
      acc = 0;
      for (int k = 0; k < 8; k++) acc += (mode ? coef(k, n) : coef(n, k)) * s[k];
      r[n] = scale(acc);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Queue expectations, then feed the 8 samples with gaps and junk outside LOAD.
  task automatic send_block(input bit mode, input int s[8], input int expv[8], input int gap_pct);
    exp_t e;
    int   i;
    int   guard;
    for (int n = 0; n < 8; n++) begin
      e.data = expv[n];
      e.idx  = n;
      e.last = (n == 7);
      sb.push_back(e);
    end
    i = 0;
    guard = 0;
    while (i < 8 && guard < 3000) begin
      if (o_ready) begin
        if (int'($urandom_range(99)) < gap_pct) begin
          i_valid = 1'b0;
          i_mode  = 1'($urandom);
        end else begin
          i_valid = 1'b1;
          i_data  = IN_W'(s[i]);
          i_mode  = (i == 0) ? mode : 1'($urandom);
          i++;
        end
      end else begin
        i_valid = 1'($urandom);
        i_data  = IN_W'($urandom);
        i_mode  = 1'($urandom);
      end
      step();
      guard++;
    end
    i_valid = 1'b0;
    check_eq("send_block_samples", i, 8);
  endtask

  task automatic wait_empty(input int limit);
    int w;
    w = 0;
    while (sb.size() != 0 && w < limit) begin
      step();
      w++;
    end
    check_eq("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_ready();
    int w;
    w = 0;
    while (!o_ready && w < 20) begin
      step();
      w++;
    end
    check_eq("ready_after_reset", int'(o_ready), 1);
  endtask

  task automatic check_zero_outputs(string tag);
    check_eq({tag, "_valid"}, int'(o_valid), 0);
    check_eq({tag, "_data"},  int'(o_data), 0);
    check_eq({tag, "_index"}, int'(o_index), 0);
    check_eq({tag, "_last"},  int'(o_last), 0);
  endtask

  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
    end
  end

  // Downstream ready: random, or always high with an optional stall on one index.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rdy_random) begin
        i_ready = (int'($urandom_range(99)) < 75);
      end else if (stall_left > 0 && o_valid && int'(o_index) == stall_idx) begin
        i_ready = 1'b0;
        stall_left--;
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  // Monitor: handshake checks, stall hold, and result latency.
  initial begin
    int       acc_cnt;
    int       t_expect;
    bit       prev_valid;
    bit       prev_stall;
    int       prev_data;
    int       prev_index;
    int       prev_last;
    exp_t     e;
    acc_cnt = 0;
    t_expect = -1;
    prev_valid = 1'b0;
    prev_stall = 1'b0;
    prev_data = 0;
    prev_index = 0;
    prev_last = 0;
    forever begin
      @(negedge i_clk);
      if (!i_arstn) begin
        acc_cnt = 0;
        prev_valid = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("stall_valid", int'(o_valid), 1);
          check_eq("stall_data",  int'($signed(o_data)), prev_data);
          check_eq("stall_index", int'(o_index), prev_index);
          check_eq("stall_last",  int'(o_last), prev_last);
        end
        if (o_valid) check_eq("ready_low_in_out", int'(o_ready), 0);
        if (o_valid && !prev_valid) check_eq("result_latency", cyc, t_expect);
        if (o_valid && i_ready) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_output", int'(o_index), -1);
          end else begin
            e = sb.pop_front();
            check_eq("data",  int'($signed(o_data)), e.data);
            check_eq("index", int'(o_index), e.idx);
            check_eq("last",  int'(o_last), int'(e.last));
          end
          if (!o_last) t_expect = cyc + 1 + 9;
        end
        if (i_valid && o_ready) begin
          acc_cnt++;
          if (acc_cnt == 8) begin
            acc_cnt = 0;
            t_expect = cyc + 1 + 9;
          end
        end
        prev_valid = o_valid;
        prev_stall = o_valid && !i_ready;
        prev_data  = int'($signed(o_data));
        prev_index = int'(o_index);
        prev_last  = int'(o_last);
      end
    end
  end

  initial begin
    int s[8];
    int e[8];
    int w;

    i_arstn = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_zero_outputs("reset");
    i_arstn = 1'b1;
    wait_ready();

    s = '{64, 0, 0, 0, 0, 0, 0, 0};
    e = '{default: 23};
    send_block(1'b0, s, e, 0);
    wait_empty(400);

    s = '{0, 100, 0, 0, 0, 0, 0, 0};
    model_block(1'b0, s, e);
    e[0] = 49;
    e[7] = -49;
    send_block(1'b0, s, e, 40);
    wait_empty(400);

    s = '{2047, 0, 0, 0, 0, 0, 0, 0};
    e = '{default: 255};
    send_block(1'b0, s, e, 0);
    wait_empty(400);

    s = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    e = '{default: -256};
    send_block(1'b0, s, e, 0);
    wait_empty(400);

    s = '{default: 10};
    e = '{28, 0, 0, 0, 0, 0, 0, 0};
    send_block(1'b1, s, e, 20);
    wait_empty(400);

    // Hold off index 3 for five cycles.
    stall_idx  = 3;
    stall_left = 5;
    s = '{64, 0, -300, 0, 0, 0, 0, 0};
    model_block(1'b0, s, e);
    send_block(1'b0, s, e, 0);
    wait_empty(400);
    check_eq("stall_consumed", stall_left, 0);

    // Reset during the fourth MAC cycle of index 2.
    s = '{64, 0, 0, 0, 0, 0, 0, 0};
    e = '{default: 23};
    send_block(1'b0, s, e, 0);
    w = 0;
    while (!(o_valid && o_index == 3'd1) && w < 200) begin
      step();
      w++;
    end
    check_eq("reached_index1", int'(o_index), 1);
    repeat (4) @(posedge i_clk);
    #1;
    i_arstn = 1'b0;
    #1;
    check_zero_outputs("midmac_reset");
    sb.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_arstn = 1'b1;
    wait_ready();
    send_block(1'b0, s, e, 0);
    wait_empty(400);

    // Random blocks, back to back, with random downstream ready.
    rdy_random = 1'b1;
    for (int b = 0; b < 20; b++) begin
      bit m;
      m = 1'($urandom);
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(7))
          0:       s[k] = 2047;
          1:       s[k] = -2048;
          2:       s[k] = 0;
          default: s[k] = int'($urandom_range(4095)) - 2048;
        endcase
      end
      model_block(m, s, e);
      send_block(m, s, e, 30);
    end
    wait_empty(6000);
    rdy_random = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
